// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: pops bytes from the SDRAM read FIFO and sends each one on
// rs232_tx as an 8N1 frame (start bit, 8 data bits LSB first, stop bit).
//
// Ports:
//   clk            system clock
//   rst            asynchronous reset, active-high
//   tx_en          permits starting a new frame
//   rfifo_empty    read FIFO empty flag
//   rfifo_rd_data  read FIFO data, valid the cycle after rfifo_rd_en
//   rfifo_rd_en    read FIFO pop strobe, one-cycle pulse per frame
//   rs232_tx       serial line, idle high
//   tx_busy        high from leaving IDLE until the stop bit completes
//   tx_done        one-cycle pulse at the end of each stop bit
module uart_tx_ctrl #(
  parameter int unsigned BAUD_END = 5208,
  parameter int unsigned BIT_END  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic       rfifo_empty,
  input  logic [7:0] rfifo_rd_data,
  output logic       rfifo_rd_en,
  output logic       rs232_tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned BAUD_W = (BAUD_END > 1) ? $clog2(BAUD_END) : 1;
  localparam int unsigned BIT_W  = 4;
  localparam int unsigned DATA_W = 8;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_END - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BIT_END - 1);
  // bit_cnt value whose wrap launches the stop bit; lower values launch data bits
  localparam logic [BIT_W-1:0]  STOP_FROM = BIT_W'(BIT_END - 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_LATCH,
    ST_SEND
  } state_e;

  state_e              state_q,    state_d;
  logic [BAUD_W-1:0]   baud_cnt_q, baud_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q,  bit_cnt_d;
  logic [DATA_W-1:0]   shift_q,    shift_d;
  logic                rd_en_q,    rd_en_d;
  logic                tx_q,       tx_d;
  logic                busy_q,     busy_d;
  logic                done_q,     done_d;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rd_en_q    <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rd_en_q    <= rd_en_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rd_en_d    = 1'b0;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (tx_en && !rfifo_empty) begin
          state_d = ST_RD;
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
        end
      end

      // FIFO output is not valid until the cycle after the pop
      ST_RD: begin
        state_d = ST_LATCH;
      end

      ST_LATCH: begin
        shift_d    = rfifo_rd_data;
        tx_d       = 1'b0;
        baud_cnt_d = '0;
        bit_cnt_d  = '0;
        state_d    = ST_SEND;
      end

      ST_SEND: begin
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            done_d    = 1'b1;
            busy_d    = 1'b0;
            tx_d      = 1'b1;
            bit_cnt_d = '0;
            state_d   = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            // data leaves LSB first by shifting right one bit per wrap
            if (bit_cnt_q < STOP_FROM) begin
              tx_d    = shift_q[0];
              shift_d = {1'b0, shift_q[DATA_W-1:1]};
            end else begin
              tx_d    = 1'b1;
            end
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rfifo_rd_en = rd_en_q;
  assign rs232_tx    = tx_q;
  assign tx_busy     = busy_q;
  assign tx_done     = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed sequence with random payload bytes. A standard-mode
// FIFO model feeds the DUT and a UART receiver model decodes rs232_tx, checking
// exact bit widths, busy/done behaviour and decoded bytes against pushed bytes.
module tb_uart_tx_ctrl;

  localparam int unsigned BAUD      = 28;
  localparam int unsigned FRAME_CLK = BAUD * 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_en = 1'b0;
  logic       rfifo_empty = 1'b1;
  logic [7:0] rfifo_rd_data = 8'h00;
  logic       rfifo_rd_en;
  logic       rs232_tx;
  logic       tx_busy;
  logic       tx_done;

  uart_tx_ctrl #(.BAUD_END(BAUD), .BIT_END(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_en        (tx_en),
    .rfifo_empty  (rfifo_empty),
    .rfifo_rd_data(rfifo_rd_data),
    .rfifo_rd_en  (rfifo_rd_en),
    .rs232_tx     (rs232_tx),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // FIFO model and edge counters
  logic [7:0] fifo_q[$];
  int cyc = 0;
  int rd_pulses = 0;
  int done_pulses = 0;
  int pop_err = 0;
  int last_rd_cyc = 0;
  int low_cnt = 0;
  int busy_cnt = 0;
  bit tog_en = 1'b0;

  // Decoded frames
  logic [7:0] fr_data[$];
  bit         fr_wave[$];
  bit         fr_busy[$];
  bit         fr_done[$];
  int         fr_fall[$];

  bit         mon_active = 1'b0;
  bit         mon_prev = 1'b1;
  bit         mon_wave_ok, mon_busy_ok, mon_done_ok;
  logic       mon_bit_val;
  int         mon_k = 0;
  int         mon_fall = 0;
  int         bidx, pos;
  logic [7:0] mon_byte;

  always @(posedge clk) begin
    if (rfifo_rd_en === 1'b1) begin
      rd_pulses++;
      last_rd_cyc = cyc;
      if (fifo_q.size() == 0) pop_err++;
      else rfifo_rd_data <= fifo_q.pop_front();
    end
    if (tx_done === 1'b1) done_pulses++;
    cyc++;
  end

  // UART receiver model: every bit must hold its level for exactly BAUD clocks
  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
      mon_prev   = 1'b1;
    end else begin
      if (rs232_tx !== 1'b1) low_cnt++;
      if (tx_busy === 1'b1) busy_cnt++;
      if (!mon_active && mon_prev && (rs232_tx === 1'b0)) begin
        mon_active  = 1'b1;
        mon_k       = 0;
        mon_wave_ok = 1'b1;
        mon_busy_ok = 1'b1;
        mon_done_ok = 1'b1;
        mon_byte    = 8'h00;
        mon_fall    = cyc;
      end
      if (mon_active) begin
        if (mon_k < int'(FRAME_CLK)) begin
          bidx = mon_k / int'(BAUD);
          pos  = mon_k % int'(BAUD);
          if (pos == 0) mon_bit_val = rs232_tx;
          else if (rs232_tx !== mon_bit_val) mon_wave_ok = 1'b0;
          if (bidx == 0 && rs232_tx !== 1'b0) mon_wave_ok = 1'b0;
          if (bidx == 9 && rs232_tx !== 1'b1) mon_wave_ok = 1'b0;
          if (bidx >= 1 && bidx <= 8 && pos == int'(BAUD / 2))
            mon_byte[3'(bidx - 1)] = rs232_tx;
          if (tx_busy !== 1'b1) mon_busy_ok = 1'b0;
          if (tx_done !== 1'b0) mon_done_ok = 1'b0;
          mon_k++;
        end else begin
          fr_data.push_back(mon_byte);
          fr_wave.push_back(mon_wave_ok && (rs232_tx === 1'b1));
          fr_busy.push_back(mon_busy_ok);
          fr_done.push_back(mon_done_ok && (tx_done === 1'b1) && (tx_busy === 1'b0));
          fr_fall.push_back(mon_fall);
          mon_active = 1'b0;
        end
      end
      mon_prev = rs232_tx;
    end
    if (tog_en && mon_active && mon_k < 250) rfifo_empty = 1'($urandom_range(0, 1));
    else rfifo_empty = (fifo_q.size() == 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frames(input int n, input string tag);
    int t;
    t = 0;
    while (fr_data.size() < n && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_timeout"}, 32'(fr_data.size() >= n), 32'd1);
  endtask

  task automatic wait_bit_pos(input int k, input string tag);
    int t;
    t = 0;
    while (!(mon_active && mon_k >= k) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_reach"}, 32'(t < 5000), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed cycle %0d expected finish", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    int base, rd0, dn0, l0, b0, pe0;
    logic [7:0] six[6];
    logic [7:0] rnd[4];
    logic [7:0] a, b;

    six = '{8'hAA, 8'h01, 8'h02, 8'h03, 8'h04, 8'h55};

    // Reset values
    rst = 1'b1;
    tx_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx",    32'(rs232_tx),    32'd1);
    chk("rst_rd_en", 32'(rfifo_rd_en), 32'd0);
    chk("rst_busy",  32'(tx_busy),     32'd0);
    chk("rst_done",  32'(tx_done),     32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Empty FIFO with tx_en held: nothing may happen
    tx_en = 1'b1;
    rd0 = rd_pulses; l0 = low_cnt; b0 = busy_cnt;
    repeat (1000) @(negedge clk);
    chk("empty_rd_en",  32'(rd_pulses - rd0), 32'd0);
    chk("empty_tx_low", 32'(low_cnt - l0),    32'd0);
    chk("empty_busy",   32'(busy_cnt - b0),   32'd0);

    // Single byte 0x55
    base = fr_data.size(); rd0 = rd_pulses; dn0 = done_pulses;
    fifo_q.push_back(8'h55);
    wait_frames(base + 1, "single");
    repeat (2) @(negedge clk);
    chk("single_data",     32'(fr_data[base]),            32'h55);
    chk("single_wave",     32'(fr_wave[base]),            32'd1);
    chk("single_busy",     32'(fr_busy[base]),            32'd1);
    chk("single_done_at",  32'(fr_done[base]),            32'd1);
    chk("single_rd_cnt",   32'(rd_pulses - rd0),          32'd1);
    chk("single_done_cnt", 32'(done_pulses - dn0),        32'd1);
    chk("single_pop2fall", 32'(fr_fall[base] - last_rd_cyc), 32'd2);

    // Six preloaded bytes, back to back
    tx_en = 1'b0;
    repeat (2) @(negedge clk);
    base = fr_data.size(); rd0 = rd_pulses;
    for (int i = 0; i < 6; i++) fifo_q.push_back(six[i]);
    repeat (2) @(negedge clk);
    tx_en = 1'b1;
    wait_frames(base + 6, "six");
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("six_data%0d", i), 32'(fr_data[base + i]), 32'(six[i]));
      chk($sformatf("six_wave%0d", i), 32'(fr_wave[base + i] && fr_busy[base + i] && fr_done[base + i]), 32'd1);
    end
    for (int i = 1; i < 6; i++)
      chk($sformatf("six_gap%0d", i), 32'(fr_fall[base + i] - fr_fall[base + i - 1] - int'(BAUD * 9)),
          32'(BAUD + 3));
    chk("six_rd_cnt",   32'(rd_pulses - rd0), 32'd6);
    chk("six_busy_end", 32'(tx_busy),         32'd0);

    // Random payload
    base = fr_data.size();
    for (int i = 0; i < 4; i++) begin
      rnd[i] = 8'($urandom);
      fifo_q.push_back(rnd[i]);
    end
    wait_frames(base + 4, "rnd");
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rnd_data%0d", i), 32'(fr_data[base + i]), 32'(rnd[i]));
      chk($sformatf("rnd_wave%0d", i), 32'(fr_wave[base + i]), 32'd1);
    end

    // tx_en dropped mid-frame: current frame finishes, next is not popped
    tx_en = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'($urandom); b = 8'($urandom);
    fifo_q.push_back(a); fifo_q.push_back(b);
    base = fr_data.size(); rd0 = rd_pulses;
    tx_en = 1'b1;
    wait_bit_pos(4 * int'(BAUD) + 5, "drop");
    tx_en = 1'b0;
    repeat (FRAME_CLK + 400) @(negedge clk);
    chk("drop_frames",  32'(fr_data.size() - base), 32'd1);
    chk("drop_data",    32'(fr_data[base]),         32'(a));
    chk("drop_wave",    32'(fr_wave[base]),         32'd1);
    chk("drop_rd_cnt",  32'(rd_pulses - rd0),       32'd1);
    chk("drop_fifo",    32'(fifo_q.size()),         32'd1);
    tx_en = 1'b1;
    wait_frames(base + 2, "resume");
    chk("resume_data",  32'(fr_data[base + 1]),     32'(b));
    chk("resume_rd",    32'(rd_pulses - rd0),       32'd2);

    // Empty flag toggling while sending is ignored
    tx_en = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'($urandom); b = 8'($urandom);
    fifo_q.push_back(a); fifo_q.push_back(b);
    base = fr_data.size(); rd0 = rd_pulses; pe0 = pop_err;
    tog_en = 1'b1;
    tx_en = 1'b1;
    wait_frames(base + 2, "tog");
    tog_en = 1'b0;
    repeat (300) @(negedge clk);
    chk("tog_data0",  32'(fr_data[base]),     32'(a));
    chk("tog_data1",  32'(fr_data[base + 1]), 32'(b));
    chk("tog_wave",   32'(fr_wave[base] && fr_wave[base + 1]), 32'd1);
    chk("tog_rd_cnt", 32'(rd_pulses - rd0),   32'd2);
    chk("tog_poperr", 32'(pop_err - pe0),     32'd0);

    // Reset during data bit 3 of an all-zero byte (line is low there)
    tx_en = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'h00; b = 8'($urandom);
    fifo_q.push_back(a); fifo_q.push_back(b);
    base = fr_data.size(); rd0 = rd_pulses;
    tx_en = 1'b1;
    wait_bit_pos(4 * int'(BAUD) + 10, "rstmid");
    chk("rstmid_low_before", 32'(rs232_tx), 32'd0);
    #3 rst = 1'b1;
    #1;
    chk("rstmid_tx",   32'(rs232_tx), 32'd1);
    chk("rstmid_busy", 32'(tx_busy),  32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_frames(base + 1, "rstmid_next");
    chk("rstmid_data",   32'(fr_data[base]),   32'(b));
    chk("rstmid_wave",   32'(fr_wave[base]),   32'd1);
    chk("rstmid_rd_cnt", 32'(rd_pulses - rd0), 32'd2);
    chk("rstmid_fifo",   32'(fifo_q.size()),   32'd0);

    repeat (50) @(negedge clk);
    chk("final_poperr", 32'(pop_err),  32'd0);
    chk("final_idle",   32'(rs232_tx), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Transmit end of the RS-232 link. Drains bytes from the SDRAM read-data FIFO and serialises them onto rs232_tx as 8N1 frames.
- Counterpart of the receive path that feeds command/data bytes into the SDRAM controller.
- Sits in top between the read FIFO (standard mode, data valid the cycle after rd_en) and the rs232_tx pin.

Parameters:
- BAUD_END, 5208, clocks per bit (50 MHz / 9600). Simulation uses 28, giving 560 ns per bit.
- BIT_END, 10, bits per frame: start + 8 data + stop.

Ports:
- clk  input  1  system clock, 50 MHz
- rst  input  1  asynchronous reset, active-high
- tx_en  input  1  permits starting a new frame
- rfifo_empty  input  1  read FIFO empty flag
- rfifo_rd_data  input  8  read FIFO output data, valid one cycle after rfifo_rd_en
- rfifo_rd_en  output  1  read FIFO pop strobe, one-cycle pulse
- rs232_tx  output  1  serial line, idle high
- tx_busy  output  1  high from leaving IDLE until the stop bit completes
- tx_done  output  1  one-cycle pulse at the end of each stop bit

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - rs232_tx=1, rfifo_rd_en=0, tx_busy=0, tx_done=0.
  - baud_cnt=0, bit_cnt=0, shift register=0.
  - All outputs are registered.
- States: IDLE, RD, LATCH, SEND.
- IDLE:
  - If tx_en=1 and rfifo_empty=0 at an edge: next state RD, rfifo_rd_en<=1, tx_busy<=1.
  - Otherwise stay; rs232_tx held 1.
- RD: rfifo_rd_en<=0, next state LATCH. Exactly one pop per frame.
- LATCH:
  - shift register <= rfifo_rd_data.
  - rs232_tx<=0 (start bit), baud_cnt<=0, bit_cnt<=0, next state SEND.
- SEND:
  - baud_cnt counts 0..BAUD_END-1 and wraps to 0.
  - At wrap, bit_cnt increments and rs232_tx is updated:
    - bit_cnt 1..8 drive data[bit_cnt-1], LSB first.
    - bit_cnt 9 drives 1 (stop bit).
  - When baud_cnt=BAUD_END-1 and bit_cnt=BIT_END-1: tx_done<=1 for one cycle, tx_busy<=0, next state IDLE, rs232_tx stays 1.
- Timing:
  - Every bit, including start and stop, lasts exactly BAUD_END clocks.
  - rs232_tx falls 3 edges after the IDLE edge that samples rfifo_empty=0.
  - Back-to-back frames: line high for BAUD_END+3 clocks between the start of the stop bit and the next start bit.
- tx_en deasserted mid-frame: current frame completes; no new frame starts.
- rfifo_empty changing during RD/LATCH/SEND is ignored. The data latched in LATCH is what is sent.
- rfifo_empty=1 in IDLE: no pop, ever. Popping an empty FIFO is a bug.
- Reset mid-frame: line returns high immediately. The partially sent byte is lost and not re-popped.
- baud_cnt width is ceil(log2(BAUD_END)); bit_cnt is 4 bits. No other arithmetic.

Test Plan:
- Single byte, BAUD_END=28, FIFO holds 0x55, tx_en=1:
  - one rd_en pulse;
  - rs232_tx low 28 clk, then bits 1,0,1,0,1,0,1,0 at 28 clk each, then high 28 clk;
  - tx_done pulses once, 280 clk after the start-bit fall.
- Six bytes 0xAA,0x01,0x02,0x03,0x04,0x55 preloaded:
  - six frames decoded correctly by a bench UART RX model;
  - exactly 6 rd_en pulses;
  - inter-frame high gap between frames is 31 clk;
  - tx_busy goes low only after the last frame.
- Empty FIFO with tx_en=1 for 1000 clk -> rd_en never asserted, rs232_tx constant 1, tx_busy 0.
- tx_en dropped during bit 4 of the first of two queued bytes -> first frame completes intact, second never popped. Re-asserting tx_en sends the second byte.
- rst pulsed during data bit 3 -> rs232_tx=1 and tx_busy=0 within the reset assertion. After release with the FIFO non-empty, the next byte starts cleanly with a full 28-clk start bit.
- rfifo_empty toggled during SEND -> no extra rd_en pulses and transmitted data unchanged.
